// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and index helpers for the edge event arbiter.
// Used by rr_arbiter and edge_event_arbiter.
package edge_arb_pkg;

    typedef enum logic {
        POL_FALL = 1'b0,
        POL_RISE = 1'b1
    } pol_e;

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_e;

    // Channel index + 1, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // (base + off) mod n, for base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event stream carrying channel index and edge polarity.
// The arbiter drives it through the master modport, the consumer uses slave.
interface edge_event_arbiter_if #(
    parameter int N_CH = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_chan;
    logic            evt_pol;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_pol,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_pol,
        output evt_ready
    );

endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational rotate-priority pick: first requesting index at or after ptr,
// wrapping from N-1 to 0.
module rr_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    always_comb begin
        logic [IW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'(wrap_add(int'(ptr), i, N));
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection, pending-event capture and round-robin delivery
// onto one valid/ready stream. Optional sticky overflow flags: EDGE_ARB_OVF_EN.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     sig,
    input  logic [N_CH-1:0]     pos_en,
    input  logic [N_CH-1:0]     neg_en,
    edge_event_arbiter_if.master evt,
    output logic                busy
`ifdef EDGE_ARB_OVF_EN
    ,
    output logic [N_CH-1:0]     ovf,
    input  logic [N_CH-1:0]     ovf_clr
`endif
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0] sig_r;
    logic [N_CH-1:0] pend_pos;
    logic [N_CH-1:0] pend_neg;
    logic [N_CH-1:0] older;
    logic [CH_W-1:0] rr_ptr;
    state_e          state;
    state_e          state_n;
    logic [CH_W-1:0] chan_q;
    logic [CH_W-1:0] chan_n;
    pol_e            pol_q;
    pol_e            pol_n;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] clr_sel;
    logic [N_CH-1:0] clr_pos;
    logic [N_CH-1:0] clr_neg;
    logic [N_CH-1:0] keep_pos;
    logic [N_CH-1:0] keep_neg;
    logic [N_CH-1:0] pend_pos_n;
    logic [N_CH-1:0] pend_neg_n;
    logic [N_CH-1:0] older_n;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] pick_pol;
    logic            hs;
    logic [CH_W-1:0] arb_ptr;
    logic            gnt_vld;
    logic [CH_W-1:0] gnt_idx;

    assign rise = sig & ~sig_r & pos_en;
    assign fall = ~sig & sig_r & neg_en;

    assign hs      = (state == ST_PRESENT) && evt.evt_ready;
    assign clr_sel = N_CH'(1) << chan_q;
    assign clr_pos = (hs && pol_q == POL_RISE) ? clr_sel : '0;
    assign clr_neg = (hs && pol_q == POL_FALL) ? clr_sel : '0;

    // Pending state after this cycle's handshake clear; new edges are OR-ed on top,
    // so a same-cycle set beats the clear and an edge onto a kept bit is a drop.
    assign keep_pos   = pend_pos & ~clr_pos;
    assign keep_neg   = pend_neg & ~clr_neg;
    assign pend_pos_n = keep_pos | rise;
    assign pend_neg_n = keep_neg | fall;

    // older=1 means the rising event was pending first; when nothing survives the
    // clear, the newly arriving edge becomes the older one.
    assign older_n = (keep_pos & keep_neg & older)
                   | (keep_pos & ~keep_neg)
                   | (~keep_pos & ~keep_neg & rise);

    // The event being handed over is excluded, so the winner here is what loads next.
    assign req      = keep_pos | keep_neg;
    assign pick_pol = (keep_pos & keep_neg & older) | (keep_pos & ~keep_neg);
    assign arb_ptr  = hs ? CH_W'(wrap_inc(int'(chan_q), N_CH)) : rr_ptr;

    rr_arbiter #(
        .N (N_CH)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (arb_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_r    <= '0;
            pend_pos <= '0;
            pend_neg <= '0;
            older    <= '0;
            rr_ptr   <= '0;
            state    <= ST_IDLE;
            chan_q   <= '0;
            pol_q    <= POL_FALL;
        end else begin
            sig_r    <= sig;
            pend_pos <= pend_pos_n;
            pend_neg <= pend_neg_n;
            older    <= older_n;
            rr_ptr   <= arb_ptr;
            state    <= state_n;
            chan_q   <= chan_n;
            pol_q    <= pol_n;
        end
    end

    always_comb begin
        state_n = state;
        chan_n  = chan_q;
        pol_n   = pol_q;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_n = ST_PRESENT;
                    chan_n  = gnt_idx;
                    pol_n   = pol_e'(pick_pol[gnt_idx]);
                end
            end
            ST_PRESENT: begin
                if (hs) begin
                    if (gnt_vld) begin
                        chan_n = gnt_idx;
                        pol_n  = pol_e'(pick_pol[gnt_idx]);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign evt.evt_valid = (state == ST_PRESENT);
    assign evt.evt_chan  = chan_q;
    assign evt.evt_pol   = pol_q;
    assign busy          = (|pend_pos) | (|pend_neg) | (state == ST_PRESENT);

`ifdef EDGE_ARB_OVF_EN
    logic [N_CH-1:0] drop;
    assign drop = (rise & keep_pos) | (fall & keep_neg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | drop;
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: vector table plus hand-written stall,
// drop/overflow (EDGE_ARB_OVF_EN) and mid-operation reset sequences.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sig;
    logic [7:0] pos_en;
    logic [7:0] neg_en;
    logic       busy;
`ifdef EDGE_ARB_OVF_EN
    logic [7:0] ovf;
    logic [7:0] ovf_clr;
`endif

    int errors = 0;
    int checks = 0;

    edge_event_arbiter_if #(.N_CH(8)) evt_if ();

    edge_event_arbiter #(
        .N_CH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sig     (sig),
        .pos_en  (pos_en),
        .neg_en  (neg_en),
        .evt     (evt_if.master),
        .busy    (busy)
`ifdef EDGE_ARB_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic [7:0] sig;
        logic [7:0] neg_en;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_chan;
        logic       exp_pol;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic r, input logic [7:0] s, input logic [7:0] ne,
                                input logic rdy, input logic ev, input logic [2:0] ec,
                                input logic ep, input logic eb);
        vec_t v;
        v.rst_first = r;
        v.sig       = s;
        v.neg_en    = ne;
        v.ready     = rdy;
        v.exp_valid = ev;
        v.exp_chan  = ec;
        v.exp_pol   = ep;
        v.exp_busy  = eb;
        return v;
    endfunction

    task automatic checkEq(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sig              = v.sig;
        pos_en           = 8'hFF;
        neg_en           = v.neg_en;
        evt_if.evt_ready = v.ready;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkEq({tag, " valid"}, 8'(evt_if.evt_valid), 8'(v.exp_valid));
        checkEq({tag, " busy"}, 8'(busy), 8'(v.exp_busy));
        if (v.exp_valid) begin
            checkEq({tag, " chan"}, 8'(evt_if.evt_chan), 8'(v.exp_chan));
            checkEq({tag, " pol"}, 8'(evt_if.evt_pol), 8'(v.exp_pol));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, " valid"}, 8'(evt_if.evt_valid), 8'd0);
        checkEq({tag, " busy"}, 8'(busy), 8'd0);
        checkEq({tag, " chan"}, 8'(evt_if.evt_chan), 8'd0);
        checkEq({tag, " pol"}, 8'(evt_if.evt_pol), 8'd0);
`ifdef EDGE_ARB_OVF_EN
        checkEq({tag, " ovf"}, ovf, 8'h00);
`endif
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst              = 1'b1;
        sig              = 8'h00;
        pos_en           = 8'hFF;
        neg_en           = 8'hFF;
        evt_if.evt_ready = 1'b0;
`ifdef EDGE_ARB_OVF_EN
        ovf_clr          = 8'h00;
`endif
        @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
    endtask

    task automatic runStep(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
    endtask

    initial begin
        rst              = 1'b1;
        sig              = 8'h00;
        pos_en           = 8'hFF;
        neg_en           = 8'hFF;
        evt_if.evt_ready = 1'b0;
`ifdef EDGE_ARB_OVF_EN
        ovf_clr          = 8'h00;
`endif

        // rst_first, sig, neg_en, ready, exp valid/chan/pol/busy
        vecs[0]  = mk(1, 8'h08, 8'hFF, 1, 0, 0, 0, 1);
        vecs[1]  = mk(0, 8'h08, 8'hFF, 1, 1, 3, 1, 1);
        vecs[2]  = mk(0, 8'h08, 8'hFF, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 8'h62, 8'hFF, 1, 0, 0, 0, 1);
        vecs[5]  = mk(0, 8'h62, 8'hFF, 1, 1, 1, 1, 1);
        vecs[6]  = mk(0, 8'h62, 8'hFF, 1, 1, 5, 1, 1);
        vecs[7]  = mk(0, 8'h62, 8'hFF, 1, 1, 6, 1, 1);
        vecs[8]  = mk(0, 8'h63, 8'hFF, 1, 0, 0, 0, 1);
        vecs[9]  = mk(0, 8'h63, 8'hFF, 1, 1, 0, 1, 1);
        vecs[10] = mk(0, 8'h63, 8'hFF, 1, 0, 0, 0, 0);
        vecs[11] = mk(1, 8'h10, 8'hFF, 1, 0, 0, 0, 1);
        vecs[12] = mk(0, 8'h00, 8'hFF, 1, 1, 4, 1, 1);
        vecs[13] = mk(0, 8'h00, 8'hFF, 1, 1, 4, 0, 1);
        vecs[14] = mk(0, 8'h00, 8'hFF, 1, 0, 0, 0, 0);
        vecs[15] = mk(1, 8'h04, 8'hFB, 1, 0, 0, 0, 1);
        vecs[16] = mk(0, 8'h04, 8'hFB, 1, 1, 2, 1, 1);
        vecs[17] = mk(0, 8'h04, 8'hFB, 1, 0, 0, 0, 0);
        vecs[18] = mk(0, 8'h00, 8'hFB, 1, 0, 0, 0, 0);
        vecs[19] = mk(0, 8'h00, 8'hFB, 1, 0, 0, 0, 0);
        vecs[20] = mk(0, 8'h00, 8'hFF, 1, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst_first) resetDut();
            runStep(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall on channel 2 while other channels become pending behind it.
        resetDut();
        runStep(mk(0, 8'h04, 8'hFF, 0, 0, 0, 0, 1), "stall_pend");
        for (int i = 0; i < 10; i++) begin
            runStep(mk(0, (i >= 2) ? 8'h27 : 8'h04, 8'hFF, 0, 1, 2, 1, 1),
                    $sformatf("stall%0d", i));
        end
        runStep(mk(0, 8'h27, 8'hFF, 1, 1, 5, 1, 1), "stall_rel0");
        runStep(mk(0, 8'h27, 8'hFF, 1, 1, 0, 1, 1), "stall_rel1");
        runStep(mk(0, 8'h27, 8'hFF, 1, 1, 1, 1, 1), "stall_rel2");
        runStep(mk(0, 8'h27, 8'hFF, 1, 0, 0, 0, 0), "stall_rel3");

        // Rise, fall, rise on channel 7 while stalled: the second rise is dropped.
        resetDut();
        runStep(mk(0, 8'h80, 8'hFF, 0, 0, 0, 0, 1), "drop0");
        runStep(mk(0, 8'h00, 8'hFF, 0, 1, 7, 1, 1), "drop1");
        runStep(mk(0, 8'h80, 8'hFF, 0, 1, 7, 1, 1), "drop2");
`ifdef EDGE_ARB_OVF_EN
        checkEq("drop2 ovf", ovf, 8'h80);
`endif
        runStep(mk(0, 8'h80, 8'hFF, 1, 1, 7, 0, 1), "drop3");
        runStep(mk(0, 8'h80, 8'hFF, 1, 0, 0, 0, 0), "drop4");
`ifdef EDGE_ARB_OVF_EN
        checkEq("drop4 ovf sticky", ovf, 8'h80);
        ovf_clr = 8'h80;
        @(negedge clk);
        ovf_clr = 8'h00;
        checkEq("ovf_clr", ovf, 8'h00);
`endif

        // Reset while an event is presented and another is pending.
        resetDut();
        runStep(mk(0, 8'h18, 8'hFF, 0, 0, 0, 0, 1), "midrst0");
        runStep(mk(0, 8'h18, 8'hFF, 0, 1, 3, 1, 1), "midrst1");
        rst = 1'b1;
        #1;
        checkResetState("midrst_async");
        @(negedge clk);
        rst = 1'b0;
        runStep(mk(0, 8'h18, 8'hFF, 0, 0, 0, 0, 1), "midrst2");
        runStep(mk(0, 8'h18, 8'hFF, 0, 1, 3, 1, 1), "midrst3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
